// File: rtl/pll_cfg_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer: register map,
// FSM state encoding, shadow configuration record and counter-word packing.
package pll_cfg_pkg;

    // Reconfiguration management register addresses
    localparam int unsigned RegMode  = 0;
    localparam int unsigned RegStart = 2;
    localparam int unsigned RegN     = 3;
    localparam int unsigned RegM     = 4;
    localparam int unsigned RegC     = 5;
    localparam int unsigned RegK     = 7;
    localparam int unsigned RegBw    = 8;
    localparam int unsigned RegCp    = 9;

    // Index of the final (start) write in the step ROM
    localparam logic [2:0] LastStep = 3'd7;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StSettle,
        StWaitLock
    } state_e;

    // Latched copy of one frequency-point request
    typedef struct packed {
        logic [7:0]  m_hi;
        logic [7:0]  m_lo;
        logic        m_odd;
        logic [7:0]  n_hi;
        logic [7:0]  n_lo;
        logic        n_byp;
        logic [7:0]  c0_hi;
        logic [7:0]  c0_lo;
        logic        c0_odd;
        logic [31:0] k;
        logic [3:0]  bw;
        logic [2:0]  cp;
    } pll_cfg_t;

    // 18-bit counter word: {odd-duty, bypass, high count, low count}
    function automatic logic [17:0] pack_cnt(input logic [7:0] hi,
                                             input logic [7:0] lo,
                                             input logic       odd,
                                             input logic       byp);
        return {odd, byp, hi, lo};
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous level signal.
module sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the asynchronous input through two flops
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_cfg_seq.sv
// Runtime PLL reconfiguration sequencer. Latches a frequency-point request,
// streams it as eight back-to-back Avalon-MM writes to the PLL reconfiguration
// management port, lets the PLL settle, then waits (bounded) for lock.
module pll_cfg_seq
    import pll_cfg_pkg::*;
#(
    parameter int unsigned LOCK_TIMEOUT  = 1000000,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned ADDR_W        = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_i,
    input  logic [7:0]        cfg_m_hi_i,
    input  logic [7:0]        cfg_m_lo_i,
    input  logic              cfg_m_odd_i,
    input  logic [7:0]        cfg_n_hi_i,
    input  logic [7:0]        cfg_n_lo_i,
    input  logic              cfg_n_byp_i,
    input  logic [7:0]        cfg_c0_hi_i,
    input  logic [7:0]        cfg_c0_lo_i,
    input  logic              cfg_c0_odd_i,
    input  logic [31:0]       cfg_k_i,
    input  logic [3:0]        cfg_bw_i,
    input  logic [2:0]        cfg_cp_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] mgmt_address_o,
    output logic              mgmt_write_o,
    output logic [31:0]       mgmt_writedata_o,
    input  logic              mgmt_waitrequest_i,
    input  logic              pll_locked_i
);

    localparam int unsigned TmoW    = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned SettleW = $clog2(SETTLE_CYCLES + 1);

    state_e              state_q;
    pll_cfg_t            cfg_q;
    pll_cfg_t            cfg_in;
    logic [2:0]          step_q;
    logic [SettleW-1:0]  settle_q;
    logic [TmoW-1:0]     tmo_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic                write_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         data_q;
    logic                locked_sync;
    logic [2:0]          rom_idx;
    logic [ADDR_W-1:0]   rom_addr;
    logic [31:0]         rom_data;

    sync2 u_lock_sync (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (pll_locked_i),
        .q_o    (locked_sync)
    );

    // Gather the request fields into one record for latching
    always_comb begin
        cfg_in        = '0;
        cfg_in.m_hi   = cfg_m_hi_i;
        cfg_in.m_lo   = cfg_m_lo_i;
        cfg_in.m_odd  = cfg_m_odd_i;
        cfg_in.n_hi   = cfg_n_hi_i;
        cfg_in.n_lo   = cfg_n_lo_i;
        cfg_in.n_byp  = cfg_n_byp_i;
        cfg_in.c0_hi  = cfg_c0_hi_i;
        cfg_in.c0_lo  = cfg_c0_lo_i;
        cfg_in.c0_odd = cfg_c0_odd_i;
        cfg_in.k      = cfg_k_i;
        cfg_in.bw     = cfg_bw_i;
        cfg_in.cp     = cfg_cp_i;
    end

    // Step ROM: address/data of the write to present next. In IDLE this is
    // step 0, which is constant and so does not need the shadow registers.
    always_comb begin
        rom_idx  = (state_q == StWrite) ? step_q + 3'd1 : 3'd0;
        rom_addr = '0;
        rom_data = '0;
        unique case (rom_idx)
            3'd0: begin
                rom_addr = ADDR_W'(RegMode);
                rom_data = 32'd0;
            end
            3'd1: begin
                rom_addr = ADDR_W'(RegN);
                rom_data = {14'b0, pack_cnt(cfg_q.n_hi, cfg_q.n_lo, 1'b0, cfg_q.n_byp)};
            end
            3'd2: begin
                rom_addr = ADDR_W'(RegM);
                rom_data = {14'b0, pack_cnt(cfg_q.m_hi, cfg_q.m_lo, cfg_q.m_odd, 1'b0)};
            end
            3'd3: begin
                rom_addr = ADDR_W'(RegC);
                // Counter select field is 0: C0 is the only output reprogrammed
                rom_data = {9'b0, 5'd0,
                            pack_cnt(cfg_q.c0_hi, cfg_q.c0_lo, cfg_q.c0_odd, 1'b0)};
            end
            3'd4: begin
                rom_addr = ADDR_W'(RegK);
                rom_data = cfg_q.k;
            end
            3'd5: begin
                rom_addr = ADDR_W'(RegBw);
                rom_data = {28'b0, cfg_q.bw};
            end
            3'd6: begin
                rom_addr = ADDR_W'(RegCp);
                rom_data = {29'b0, cfg_q.cp};
            end
            3'd7: begin
                rom_addr = ADDR_W'(RegStart);
                rom_data = 32'd1;
            end
            default: begin
                rom_addr = '0;
                rom_data = '0;
            end
        endcase
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cfg_q    <= '0;
            step_q   <= '0;
            settle_q <= '0;
            tmo_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_i) begin
                        cfg_q   <= cfg_in;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        step_q  <= '0;
                        write_q <= 1'b1;
                        addr_q  <= rom_addr;
                        data_q  <= rom_data;
                        state_q <= StWrite;
                    end
                end
                StWrite: begin
                    // Hold address/data/write while the slave stalls
                    if (!mgmt_waitrequest_i) begin
                        if (step_q == LastStep) begin
                            write_q  <= 1'b0;
                            settle_q <= '0;
                            state_q  <= StSettle;
                        end else begin
                            step_q <= step_q + 3'd1;
                            addr_q <= rom_addr;
                            data_q <= rom_data;
                        end
                    end
                end
                StSettle: begin
                    if (settle_q >= SettleW'(SETTLE_CYCLES - 1)) begin
                        tmo_q   <= '0;
                        state_q <= StWaitLock;
                    end else begin
                        settle_q <= settle_q + SettleW'(1);
                    end
                end
                StWaitLock: begin
                    // Lock takes priority over a coincident timeout
                    if (locked_sync) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (tmo_q >= TmoW'(LOCK_TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (tmo_q != '1) begin
                        tmo_q <= tmo_q + TmoW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign err_o            = err_q;
    assign mgmt_write_o     = write_q;
    assign mgmt_address_o   = addr_q;
    assign mgmt_writedata_o = data_q;

endmodule

// File: doc/pll_cfg_seq.md
Name: pll_cfg_seq

Overview:
- Runtime PLL reconfiguration sequencer for the MemTest core's fractional PLL.
- Accepts a frequency-point request (M/N/C0 counters, fractional K, bandwidth, charge pump) and writes it as an Avalon-MM sequence to the PLL reconfiguration management port.
- Triggers the reconfiguration, then waits for the PLL `locked` signal.
- Sits directly upstream of the PLL wrapper: feeds its reconfiguration controller, which produces the 64-bit reconfig_to_pll bus. The memory tester uses it to sweep the SDRAM clock.

Parameters:
- LOCK_TIMEOUT, 1000000, cycles allowed between start completion and `locked` before flagging an error.
- SETTLE_CYCLES, 16, cycles to wait after the start write before `locked` is sampled.
- ADDR_W, 6, management address width.

Ports:
- clk  in  1  management clock (50 MHz refclk domain)
- rst_n  in  1  asynchronous active-low reset
- req  in  1  start request; accepted only when busy=0
- cfg_m_hi, cfg_m_lo  in  8 each  M counter high/low counts
- cfg_m_odd  in  1  M odd-division duty enable
- cfg_n_hi, cfg_n_lo  in  8 each  N counter counts
- cfg_n_byp  in  1  N bypass
- cfg_c0_hi, cfg_c0_lo  in  8 each  C0 counter counts
- cfg_c0_odd  in  1  C0 odd duty enable
- cfg_k  in  32  fractional multiplier
- cfg_bw  in  4  bandwidth code
- cfg_cp  in  3  charge-pump code
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse on successful lock
- err  out  1  sticky timeout flag; cleared by the next accepted req
- mgmt_address  out  ADDR_W  management address
- mgmt_write  out  1  write strobe
- mgmt_writedata  out  32  write data
- mgmt_waitrequest  in  1  slave stall
- pll_locked  in  1  PLL lock (asynchronous; synchronised internally)

Behaviour:
- Reset values: busy=0, done=0, err=0, mgmt_write=0, mgmt_address=0, mgmt_writedata=0. FSM=IDLE. Counters=0.
- pll_locked passes through a 2-flop synchroniser before use.
- IDLE:
  - On req=1, latch all cfg_* into shadow registers, clear err, set busy=1 on the next cycle, step=0, go to WRITE.
  - req while busy=1 is ignored; no queueing.
- WRITE: drive mgmt_write=1 with address/data from a step ROM indexed by step:
  - 0: addr 0, data 0 (waitrequest mode)
  - 1: addr 3, {14'b0, 1'b0, n_byp, n_hi, n_lo}
  - 2: addr 4, {14'b0, m_odd, 1'b0, m_hi, m_lo}
  - 3: addr 5, {9'b0, 5'd0 select, c0_odd, 1'b0, c0_hi, c0_lo}
  - 4: addr 7, k
  - 5: addr 8, {28'b0, bw}
  - 6: addr 9, {29'b0, cp}
  - 7: addr 2, data 1 (start)
- Avalon rules:
  - Address, data and write are held stable while mgmt_waitrequest=1.
  - A write completes in a cycle with mgmt_write=1 and mgmt_waitrequest=0.
  - On completion, step increments; mgmt_write stays 1 back-to-back for the next step (no idle gap).
  - After step 7 completes, deassert mgmt_write and go to SETTLE.
  - Minimum WRITE duration is 8 cycles.
- SETTLE: count SETTLE_CYCLES, then go to WAIT_LOCK with the timeout counter cleared.
- WAIT_LOCK:
  - Synchronised locked=1 → done pulses for exactly 1 cycle, busy=0 in the same cycle, FSM to IDLE.
  - Timeout counter reaching LOCK_TIMEOUT-1 without lock → err=1, busy=0, FSM to IDLE.
  - Lock and timeout in the same cycle: lock wins.
- Timeout counter width is $clog2(LOCK_TIMEOUT+1); it saturates and never wraps.
- Reset mid-sequence: everything returns immediately to reset values. A partially written PLL is left as-is; the next req rewrites all registers.
- mgmt_waitrequest stuck high in WRITE has no timeout by design; the sequencer waits.

Decomposition:
- Package pll_cfg_pkg holds:
  - the register address constants (MODE=0, START=2, N=3, M=4, C=5, K=7, BW=8, CP=9);
  - the FSM state enum {IDLE, WRITE, SETTLE, WAIT_LOCK};
  - a function packing counter fields into the 18-bit counter word.
- No sub-module except a 2-flop synchroniser, sync2, reused from the common library.

Test Plan:
- 167 MHz point: req with m 7/6 odd=1, n_byp=1, c0 2/2, k=32'h5C28F5C3, bw=6, cp=1; slave waitrequest=0.
  - Required: exactly 8 writes in 8 consecutive cycles at addresses 0,3,4,5,7,8,9,2.
  - Required data: addr 4 = 0x20706; addr 3 = 0x10000; addr 5 = 0x00202.
  - Drive locked at cycle +30: done pulses once, busy falls in the same cycle.
- Slave inserts waitrequest=1 for 3 cycles on the addr 4 write: address and data are held constant; total write phase is 11 cycles; write order unchanged.
- locked never rises, LOCK_TIMEOUT=100: err=1 and busy=0 exactly SETTLE+100 cycles after the start write; done is never asserted; a new req clears err.
- req pulsed during WAIT_LOCK with different cfg_k: ignored; the shadow K stays unchanged; no extra writes.
- rst_n low during step 4: all outputs return to reset values asynchronously; after release, a new req restarts from step 0 (addr 0).
